// File: rtl/dmem_mmio_bus.sv
// Data-side memory subsystem: byte-lane data RAM plus memory-mapped cycle
// counter and TX FIFO with a ready/valid drain port. Reads are combinational.
module dmem_mmio_bus #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = FIFO_AW + 1;

  localparam logic [31:0] RAM_BYTES   = 32'(4 * RAM_WORDS);
  localparam logic [29:0] CYCLE_WADDR = 30'h2000_0000;
  localparam logic [29:0] TXDAT_WADDR = 30'h2000_0001;
  localparam logic [29:0] STAT_WADDR  = 30'h2000_0002;

  logic [31:0]        mem [RAM_WORDS];
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [31:0]        cycle;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [CW-1:0]      count;
  logic               overflow;

  logic               ram_sel;
  logic               cycle_sel;
  logic               txdat_sel;
  logic               stat_sel;
  logic [RAM_AW-1:0]  ram_idx;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push_req;
  logic               push_ok;
  logic               ovf_clear;
  logic [31:0]        status;

  assign ram_sel   = daddr < RAM_BYTES;
  assign cycle_sel = daddr[31:2] == CYCLE_WADDR;
  assign txdat_sel = daddr[31:2] == TXDAT_WADDR;
  assign stat_sel  = daddr[31:2] == STAT_WADDR;
  assign ram_idx   = daddr[RAM_AW+1:2];

  assign full      = count == CW'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign tx_valid  = !empty;
  assign tx_data   = fifo_mem[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  assign push_req  = txdat_sel && (we == 4'b1111);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok   = push_req && (!full || pop);
  assign ovf_clear = stat_sel && (we != 4'b0000);

  always_comb begin
    status         = '0;
    status[CW-1:0] = count;
    status[8]      = full;
    status[9]      = empty;
    status[16]     = overflow;
  end

  always_comb begin
    drdata = '0;
    if (ram_sel)        drdata = mem[ram_idx];
    else if (cycle_sel) drdata = cycle;
    else if (stat_sel)  drdata = status;
  end

  always_ff @(posedge clk) begin
    if (!reset && ram_sel) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                           cycle <= '0;
    else if (cycle_sel && we == 4'b1111) cycle <= dwdata;
    else                                 cycle <= cycle + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= dwdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_clear)                overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Self-checking bench for dmem_mmio_bus: vector table for RAM/MMIO decode,
// hand sequences for counter/FIFO timing, scoreboard queue for the TX port.
module tb_dmem_mmio_bus;

  localparam logic [31:0] A_CYC  = 32'h8000_0000;
  localparam logic [31:0] A_TXD  = 32'h8000_0004;
  localparam logic [31:0] A_STAT = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] sb[$];

  dmem_mmio_bus #(.RAM_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .we(we),
    .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v, input bit accept);
    daddr  = A_TXD;
    dwdata = v;
    we     = 4'b1111;
    if (accept) sb.push_back(v);
    tick();
    we = 4'b0000;
  endtask

  // TX port monitor: pops the scoreboard on each handshake and checks the
  // head stays stable while stalled.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (prev_hold && tx_valid) check("tx_data_stable", tx_data, prev_data);
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) check("tx_unexpected_pop", tx_data, 32'hxxxx_xxxx);
      else check("tx_data_order", tx_data, sb.pop_front());
    end
    prev_hold = tx_valid && !tx_ready && !reset;
    prev_data = tx_data;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'h10,  32'hAABBCCDD, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{32'h10,  32'h11223344, 4'h5, 1'b0, 32'h0};
    vecs[2]  = '{32'h10,  32'h0,        4'h0, 1'b1, 32'hAA22CC44};
    vecs[3]  = '{32'h13,  32'h0,        4'h0, 1'b1, 32'hAA22CC44};
    vecs[4]  = '{32'h14,  32'h0,        4'hF, 1'b0, 32'h0};
    vecs[5]  = '{32'h14,  32'hFFFFFFFF, 4'h8, 1'b0, 32'h0};
    vecs[6]  = '{32'h14,  32'h0,        4'h0, 1'b1, 32'hFF000000};
    vecs[7]  = '{32'h3FC, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[8]  = '{32'h3FC, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{32'h0,   32'h0,        4'hF, 1'b0, 32'h0};
    vecs[10] = '{32'h400, 32'h55,       4'hF, 1'b0, 32'h0};
    vecs[11] = '{32'h0,   32'h0,        4'h0, 1'b1, 32'h0};
    vecs[12] = '{32'h400, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[13] = '{A_TXD,   32'h0,        4'h0, 1'b1, 32'h0};
    vecs[14] = '{32'h8000_000C, 32'h0,  4'h0, 1'b1, 32'h0};

    reset = 1'b1; daddr = '0; dwdata = '0; we = '0; tx_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    daddr = A_CYC;

    // Cycle 1 after reset: reset state
    @(negedge clk);
    check("reset_cycle", drdata, 32'h0);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    repeat (4) tick();
    @(negedge clk);
    check("cycle_5th", drdata, 32'd4);
    tick();

    for (int i = 0; i < 15; i++) begin
      daddr = vecs[i].addr; dwdata = vecs[i].wdata; we = vecs[i].we;
      @(negedge clk);
      if (vecs[i].chk) check($sformatf("vec%0d", i), drdata, vecs[i].exp);
      tick();
    end
    we = '0;

    // Cycle counter load and wrap
    daddr = A_CYC; dwdata = 32'hFFFF_FFFE; we = 4'hF;
    tick();
    we = '0;
    @(negedge clk); check("cyc_load", drdata, 32'hFFFF_FFFE);
    tick();
    @(negedge clk); check("cyc_max", drdata, 32'hFFFF_FFFF);
    tick();
    we = 4'b0011; dwdata = 32'h1234_5678;
    @(negedge clk); check("cyc_wrap", drdata, 32'h0);
    tick();
    we = '0;
    @(negedge clk); check("cyc_partial_we", drdata, 32'h1);
    tick();

    // FIFO fill and overflow
    push(32'd1, 1); push(32'd2, 1); push(32'd3, 1); push(32'd4, 1);
    daddr = A_STAT;
    @(negedge clk);
    check("stat_full", drdata, 32'h0000_0104);
    check("tx_valid_full", {31'b0, tx_valid}, 32'h1);
    tick();
    push(32'd5, 0);
    daddr = A_STAT;
    @(negedge clk);
    check("stat_ovf", drdata, 32'h0001_0104);
    check("tx_head", tx_data, 32'd1);
    tick();
    we = 4'b0001;
    tick();
    we = '0;
    @(negedge clk); check("stat_ovf_clr", drdata, 32'h0000_0104);
    tick();

    // Drain
    tx_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("drain_valid", {31'b0, tx_valid}, 32'h0);
    check("drain_stat", drdata, 32'h0000_0200);
    check("drain_sb", 32'(sb.size()), 32'h0);
    tx_ready = 1'b0;
    tick();

    // Full FIFO with simultaneous push and pop
    push(32'd5, 1); push(32'd6, 1); push(32'd7, 1); push(32'd8, 1);
    tx_ready = 1'b1;
    push(32'd9, 1);
    daddr = A_STAT;
    @(negedge clk); check("simul_stat", drdata, 32'h0000_0104);
    repeat (4) tick();
    @(negedge clk);
    check("simul_valid", {31'b0, tx_valid}, 32'h0);
    check("simul_sb", 32'(sb.size()), 32'h0);
    tx_ready = 1'b0;
    tick();

    // Reset mid-burst
    daddr = 32'h20; dwdata = 32'h1111_1111; we = 4'hF;
    tick();
    push(32'hA, 1); push(32'hB, 1); push(32'hC, 1);
    reset = 1'b1; daddr = 32'h20; dwdata = 32'h2222_2222; we = 4'hF;
    tick();
    reset = 1'b0; we = '0;
    sb.delete();
    daddr = A_CYC;
    @(negedge clk);
    check("rst_cycle", drdata, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    tick();
    daddr = A_STAT;
    @(negedge clk); check("rst_stat", drdata, 32'h0000_0200);
    tick();
    daddr = 32'h20;
    @(negedge clk); check("rst_ram_kept", drdata, 32'h1111_1111);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
